branch_history_manager: RTL and testbench

- Upstream stage of the pattern history table in the branch predictor.
- Owns the speculative 3-bit global history register (GHR) used to index the table.
- Checkpoints history and prediction of every in-flight branch in a small FIFO, in order.
- At resolution, issues the table update (index, outcome, update strobe), detects mispredicts and repairs the GHR.

---
 rtl/branch_history_manager_if.sv | 35 +++
 rtl/branch_history_manager.sv | 126 ++++++++++++
 tb/tb_branch_history_manager.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_history_manager_if.sv
// Handshake/bus bundle for branch_history_manager: fetch and resolve inputs,
// speculative history, table-update outputs and occupancy status.
interface branch_history_manager_if #(
    parameter int GHR_W = 3,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             fetch_branch;
    logic             fetch_pred;
    logic             resolve_valid;
    logic             resolve_taken;
    logic [GHR_W-1:0] GHR;
    logic [GHR_W-1:0] pht_GHR;
    logic             pht_taken;
    logic             pht_update;
    logic             mispredict;
    logic             inflight_full;
    logic [CW-1:0]    inflight_count;
    logic [7:0]       mispredict_cnt;

    // Design side
    modport slave (
        input  fetch_branch, fetch_pred, resolve_valid, resolve_taken,
        output GHR, pht_GHR, pht_taken, pht_update, mispredict,
               inflight_full, inflight_count, mispredict_cnt
    );

    // Fetch/resolve/table side
    modport master (
        output fetch_branch, fetch_pred, resolve_valid, resolve_taken,
        input  GHR, pht_GHR, pht_taken, pht_update, mispredict,
               inflight_full, inflight_count, mispredict_cnt
    );
endinterface

// File: rtl/branch_history_manager.sv
// branch_history_manager: speculative global history register plus an in-order
// checkpoint FIFO of (history, prediction) for every in-flight branch. On
// resolve it emits the table update one cycle later, detects mispredicts and
// restores the history from the checkpoint.
// Optional: define BRANCH_HISTORY_MISPREDICT_CNT_EN for a saturating 8-bit
// mispredict counter; otherwise mispredict_cnt is tied to zero.
module branch_history_manager #(
    parameter int GHR_W = 3,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    branch_history_manager_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    // Checkpoint storage; contents are only meaningful between rd and wr
    logic [GHR_W-1:0] fifo_ghr_q  [DEPTH];
    logic             fifo_pred_q [DEPTH];

    logic [GHR_W-1:0] ghr_q, ghr_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [GHR_W-1:0] pht_ghr_q, pht_ghr_d;
    logic             pht_taken_q, pht_taken_d;
    logic             pht_update_q, mispredict_q;

    logic             pop, push, flush;
    logic [GHR_W-1:0] head_ghr;
    logic             head_pred;

    assign head_ghr  = fifo_ghr_q[rd_q];
    assign head_pred = fifo_pred_q[rd_q];

    // A mispredict discards the wrong-path fetch arriving in the same cycle
    assign pop   = bus.resolve_valid && (cnt_q != '0);
    assign flush = pop && (head_pred != bus.resolve_taken);
    assign push  = bus.fetch_branch && ((cnt_q < CW'(DEPTH)) || pop) && !flush;

    // Next-state: history repair on flush, speculative shift on push
    always_comb begin
        ghr_d       = ghr_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        pht_ghr_d   = pht_ghr_q;
        pht_taken_d = pht_taken_q;

        if (pop) begin
            rd_d        = rd_q + PW'(1);
            pht_ghr_d   = head_ghr;
            pht_taken_d = bus.resolve_taken;
        end

        if (flush) begin
            ghr_d = {head_ghr[GHR_W-2:0], bus.resolve_taken};
            wr_d  = rd_q + PW'(1);
            cnt_d = '0;
        end else begin
            if (push) begin
                ghr_d = {ghr_q[GHR_W-2:0], bus.fetch_pred};
                wr_d  = wr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q        <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            pht_ghr_q    <= '0;
            pht_taken_q  <= 1'b0;
            pht_update_q <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            ghr_q        <= ghr_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            pht_ghr_q    <= pht_ghr_d;
            pht_taken_q  <= pht_taken_d;
            pht_update_q <= pop;
            mispredict_q <= flush;
        end
    end

    // Checkpoint write: history before the shift plus the prediction used
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_ghr_q[wr_q]  <= ghr_q;
            fifo_pred_q[wr_q] <= bus.fetch_pred;
        end
    end

`ifdef BRANCH_HISTORY_MISPREDICT_CNT_EN
    logic [7:0] mcnt_q;

    // Saturating mispredict counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcnt_q <= '0;
        end else if (flush && (mcnt_q != 8'hFF)) begin
            mcnt_q <= mcnt_q + 8'd1;
        end
    end

    assign bus.mispredict_cnt = mcnt_q;
`else
    assign bus.mispredict_cnt = 8'd0;
`endif

    assign bus.GHR            = ghr_q;
    assign bus.pht_GHR        = pht_ghr_q;
    assign bus.pht_taken      = pht_taken_q;
    assign bus.pht_update     = pht_update_q;
    assign bus.mispredict     = mispredict_q;
    assign bus.inflight_count = cnt_q;
    assign bus.inflight_full  = (cnt_q == CW'(DEPTH));

endmodule

// File: tb/tb_branch_history_manager.sv
// Self-checking bench for branch_history_manager: queue-based reference model,
// per-cycle comparison, directed scenarios with literal expectations, random phase.
module tb_branch_history_manager;
    localparam int GHR_W = 3;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;

    branch_history_manager_if #(.GHR_W(GHR_W), .DEPTH(DEPTH)) bus ();

    branch_history_manager #(.GHR_W(GHR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [GHR_W-1:0] ghr;
        logic             pred;
    } ent_t;

    ent_t             mq[$];
    logic [GHR_W-1:0] m_ghr;
    logic [GHR_W-1:0] m_pg;
    logic             m_pt;
    logic             m_pu;
    logic             m_mis;
    int               m_mcnt;

    initial begin
        m_ghr = '0; m_pg = '0; m_pt = 0; m_pu = 0; m_mis = 0; m_mcnt = 0;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_ghr = '0; m_pg = '0; m_pt = 0; m_pu = 0; m_mis = 0; m_mcnt = 0;
            end else begin
                automatic bit pop   = bus.resolve_valid && (mq.size() != 0);
                automatic bit flush = pop && (mq[0].pred != bus.resolve_taken);
                automatic bit push  = bus.fetch_branch && ((mq.size() < DEPTH) || pop) && !flush;
                automatic ent_t head;
                m_pu  = pop;
                m_mis = flush;
                if (pop) begin
                    head = mq.pop_front();
                    m_pg = head.ghr;
                    m_pt = bus.resolve_taken;
                end
                if (flush) begin
                    mq.delete();
                    m_ghr = {head.ghr[GHR_W-2:0], bus.resolve_taken};
`ifdef BRANCH_HISTORY_MISPREDICT_CNT_EN
                    if (m_mcnt < 255) m_mcnt++;
`endif
                end else if (push) begin
                    mq.push_back('{ghr: m_ghr, pred: bus.fetch_pred});
                    m_ghr = {m_ghr[GHR_W-2:0], bus.fetch_pred};
                end
            end
        end
    end

    // Per-cycle compare on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            chk("GHR",            32'(bus.GHR),            32'(m_ghr));
            chk("pht_GHR",        32'(bus.pht_GHR),        32'(m_pg));
            chk("pht_taken",      32'(bus.pht_taken),      32'(m_pt));
            chk("pht_update",     32'(bus.pht_update),     32'(m_pu));
            chk("mispredict",     32'(bus.mispredict),     32'(m_mis));
            chk("inflight_count", 32'(bus.inflight_count), 32'(mq.size()));
            chk("inflight_full",  32'(bus.inflight_full),  32'(mq.size() == DEPTH));
            chk("mispredict_cnt", 32'(bus.mispredict_cnt), 32'(m_mcnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input logic fb, input logic fp, input logic rv, input logic rt);
        bus.fetch_branch  = fb;
        bus.fetch_pred    = fp;
        bus.resolve_valid = rv;
        bus.resolve_taken = rt;
        @(posedge clk);
        #1;
    endtask

    logic [GHR_W-1:0] saved_ghr;

    initial begin
        reset = 1'b1;
        bus.fetch_branch = 0; bus.fetch_pred = 0;
        bus.resolve_valid = 0; bus.resolve_taken = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_GHR",   32'(bus.GHR), 32'd0);
        chk("rst_count", 32'(bus.inflight_count), 32'd0);
        chk("rst_pu",    32'(bus.pht_update), 32'd0);
        reset = 1'b0;

        // Three predictions 1,1,0
        cyc(1, 1, 0, 0); chk("d1_GHR", 32'(bus.GHR), 32'b001);
        cyc(1, 1, 0, 0); chk("d2_GHR", 32'(bus.GHR), 32'b011);
        cyc(1, 0, 0, 0); chk("d3_GHR", 32'(bus.GHR), 32'b110);
        chk("d3_count", 32'(bus.inflight_count), 32'd3);
        chk("d3_pu",    32'(bus.pht_update), 32'd0);

        // Correct resolve of the oldest (pred 1, ghr 000)
        cyc(0, 0, 1, 1);
        chk("r1_pu",  32'(bus.pht_update), 32'd1);
        chk("r1_pg",  32'(bus.pht_GHR), 32'b000);
        chk("r1_pt",  32'(bus.pht_taken), 32'd1);
        chk("r1_mis", 32'(bus.mispredict), 32'd0);
        chk("r1_cnt", 32'(bus.inflight_count), 32'd2);
        chk("r1_GHR", 32'(bus.GHR), 32'b110);

        // Mispredict (head pred 1, ghr 001) with a same-cycle fetch that gets dropped
        cyc(1, 1, 1, 0);
        chk("m1_mis", 32'(bus.mispredict), 32'd1);
        chk("m1_pg",  32'(bus.pht_GHR), 32'b001);
        chk("m1_pt",  32'(bus.pht_taken), 32'd0);
        chk("m1_GHR", 32'(bus.GHR), 32'b010);
        chk("m1_cnt", 32'(bus.inflight_count), 32'd0);

        // Fill to DEPTH
        repeat (4) cyc(1, 1, 0, 0);
        chk("f_full", 32'(bus.inflight_full), 32'd1);
        chk("f_GHR",  32'(bus.GHR), 32'b111);
        cyc(1, 0, 0, 0);
        chk("f_drop_GHR", 32'(bus.GHR), 32'b111);
        chk("f_drop_cnt", 32'(bus.inflight_count), 32'd4);
        cyc(1, 0, 1, 1);
        chk("f_pp_cnt", 32'(bus.inflight_count), 32'd4);
        chk("f_pp_GHR", 32'(bus.GHR), 32'b110);

        // Flush everything, then resolve on empty
        cyc(0, 0, 1, 0);
        chk("e_cnt", 32'(bus.inflight_count), 32'd0);
        saved_ghr = bus.GHR;
        cyc(0, 0, 1, 1);
        chk("e_pu",  32'(bus.pht_update), 32'd0);
        chk("e_mis", 32'(bus.mispredict), 32'd0);
        chk("e_GHR", 32'(bus.GHR), 32'(saved_ghr));

        // Mid-stream asynchronous reset with three in flight
        repeat (3) cyc(1, 1, 0, 0);
        chk("ar_cnt_pre", 32'(bus.inflight_count), 32'd3);
        #2 reset = 1'b1;
        #1;
        chk("ar_GHR", 32'(bus.GHR), 32'd0);
        chk("ar_cnt", 32'(bus.inflight_count), 32'd0);
        chk("ar_pg",  32'(bus.pht_GHR), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Random phase; producer mostly honours inflight_full
        for (int i = 0; i < 3000; i++) begin
            automatic logic fb = ($urandom_range(0, 2) != 0);
            automatic logic fp = $urandom_range(0, 1);
            automatic logic rv = ($urandom_range(0, 2) == 0);
            automatic logic rt = $urandom_range(0, 1);
            if (bus.inflight_full && ($urandom_range(0, 3) != 0)) fb = 0;
            if (mq.size() != 0) rt = ($urandom_range(0, 4) == 0) ? !mq[0].pred : mq[0].pred;
            cyc(fb, fp, rv, rt);
        end

        // Counter saturation
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 260; i++) begin
            cyc(1, 1, 0, 0);
            cyc(0, 0, 1, 0);
        end
`ifdef BRANCH_HISTORY_MISPREDICT_CNT_EN
        chk("sat_mcnt", 32'(bus.mispredict_cnt), 32'd255);
`else
        chk("sat_mcnt", 32'(bus.mispredict_cnt), 32'd0);
`endif
        cyc(0, 0, 0, 0);

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
